// File: rtl/writeback_regfile.sv
// ---------------------------------------------------------------------------
// writeback_regfile
//   Writeback stage plus architectural register file for an in-order pipeline.
//   Selects the writeback value (load data or ALU result), commits it to the
//   register array on the rising edge, and serves two zero-latency read ports
//   with write-through bypass so decode sees a value in the same cycle it is
//   written back. Register 0 is hardwired to zero.
//
//   Parameters
//     DATA_WIDTH  width of every data path and register entry
//     ADDR_WIDTH  register index width (2^ADDR_WIDTH entries)
//
//   Ports
//     clk                   clock, all state updates on the rising edge
//     reset                 synchronous, active-high; clears array and counter
//     memToRegInput         writeback source: 1 = memory data, 0 = ALU result
//     regWriteInput         register write request
//     dataMemoryInput       load data from MEM/WB
//     aluResultInput        ALU result from MEM/WB
//     regWriteAddressInput  destination register index
//     readAddressA/B        decode-stage source indices
//     readDataA/B           source operands (bypassed)
//     writeBackData         selected writeback value, for forwarding
//     writeBackValid        a write commits at the next edge
//     retireCount           number of committed register writes (wraps)
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// wb_rd_port
//   One combinational read port. Index 0 always reads zero, even when the
//   writeback targets it. A matching in-flight writeback overrides the array.
//
//   Ports
//     rd_addr   source index
//     entries   full register array contents
//     byp_vld   writeback commits this cycle (already gated by reset)
//     byp_addr  writeback destination index
//     byp_data  writeback value
//     rd_data   operand
// ---------------------------------------------------------------------------
module wb_rd_port #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic [ADDR_WIDTH-1:0]                       rd_addr,
    input  logic [(1<<ADDR_WIDTH)-1:0][DATA_WIDTH-1:0]  entries,
    input  logic                                        byp_vld,
    input  logic [ADDR_WIDTH-1:0]                       byp_addr,
    input  logic [DATA_WIDTH-1:0]                       byp_data,
    output logic [DATA_WIDTH-1:0]                       rd_data
);

    always_comb begin
        rd_data = entries[rd_addr];
        if (rd_addr == '0)
            rd_data = '0;
        else if (byp_vld && (rd_addr == byp_addr))
            rd_data = byp_data;
    end

endmodule

module writeback_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  memToRegInput,
    input  logic                  regWriteInput,
    input  logic [DATA_WIDTH-1:0] dataMemoryInput,
    input  logic [DATA_WIDTH-1:0] aluResultInput,
    input  logic [ADDR_WIDTH-1:0] regWriteAddressInput,
    input  logic [ADDR_WIDTH-1:0] readAddressA,
    input  logic [ADDR_WIDTH-1:0] readAddressB,
    output logic [DATA_WIDTH-1:0] readDataA,
    output logic [DATA_WIDTH-1:0] readDataB,
    output logic [DATA_WIDTH-1:0] writeBackData,
    output logic                  writeBackValid,
    output logic [31:0]           retireCount
);

    localparam int ENTRIES  = 1 << ADDR_WIDTH;
    localparam int NUM_RD   = 2;

    typedef struct packed {
        logic                  vld;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } wb_req_t;

    wb_req_t                               wb;
    logic [ENTRIES-1:0][DATA_WIDTH-1:0]    regs;
    logic [31:0]                           retire_cnt;
    logic [NUM_RD-1:0][ADDR_WIDTH-1:0]     rd_addr;
    logic [NUM_RD-1:0][DATA_WIDTH-1:0]     rd_data;

    // Writeback request. Reset gates validity so a write presented during
    // reset neither commits, bypasses, nor counts. Writes to r0 are dropped
    // here, which keeps r0 storage at its reset value forever.
    always_comb begin
        wb.data = memToRegInput ? dataMemoryInput : aluResultInput;
        wb.addr = regWriteAddressInput;
        wb.vld  = regWriteInput && (regWriteAddressInput != '0) && !reset;
    end

    always_ff @(posedge clk) begin
        if (reset)
            regs <= '0;
        else if (wb.vld)
            regs[wb.addr] <= wb.data;
    end

    always_ff @(posedge clk) begin
        if (reset)
            retire_cnt <= '0;
        else if (wb.vld)
            retire_cnt <= retire_cnt + 32'd1;
    end

    assign rd_addr = {readAddressB, readAddressA};

    generate
        for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
            wb_rd_port #(
                .DATA_WIDTH (DATA_WIDTH),
                .ADDR_WIDTH (ADDR_WIDTH)
            ) u_rd (
                .rd_addr  (rd_addr[p]),
                .entries  (regs),
                .byp_vld  (wb.vld),
                .byp_addr (wb.addr),
                .byp_data (wb.data),
                .rd_data  (rd_data[p])
            );
        end
    endgenerate

    assign readDataA      = rd_data[0];
    assign readDataB      = rd_data[1];
    assign writeBackData  = wb.data;
    assign writeBackValid = wb.vld;
    assign retireCount    = retire_cnt;

endmodule

// File: tb/tb_writeback_regfile.sv
module tb_writeback_regfile;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        memToRegInput = 1'b0;
    logic        regWriteInput = 1'b0;
    logic [31:0] dataMemoryInput = '0;
    logic [31:0] aluResultInput = '0;
    logic [4:0]  regWriteAddressInput = '0;
    logic [4:0]  readAddressA = '0;
    logic [4:0]  readAddressB = '0;
    logic [31:0] readDataA, readDataB, writeBackData, retireCount;
    logic        writeBackValid;

    writeback_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk                  (clk),
        .reset                (reset),
        .memToRegInput        (memToRegInput),
        .regWriteInput        (regWriteInput),
        .dataMemoryInput      (dataMemoryInput),
        .aluResultInput       (aluResultInput),
        .regWriteAddressInput (regWriteAddressInput),
        .readAddressA         (readAddressA),
        .readAddressB         (readAddressB),
        .readDataA            (readDataA),
        .readDataB            (readDataB),
        .writeBackData        (writeBackData),
        .writeBackValid       (writeBackValid),
        .retireCount          (retireCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          chk;
        logic [31:0] rda, rdb, wbd, rc;
        logic        wbv;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mdl [32];   // architectural register state after the last edge
    logic [31:0] mcnt;       // committed writes after the last edge
    int          n_chk  = 0;
    int          n_fail = 0;

    function automatic void cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference read: r0 is zero; a committing write to the same index is
    // visible immediately; otherwise the last committed value.
    function automatic logic [31:0] ref_rd(input logic [4:0] ra, input bit v,
                                           input logic [4:0] wa, input logic [31:0] wd);
        if (ra == 0) return 32'h0;
        if (v && ra == wa) return wd;
        return mdl[ra];
    endfunction

    // Drive one cycle of stimulus just after the rising edge, queue the
    // response the outputs must show before the next edge, then advance the
    // model to the state that edge will leave behind.
    task automatic step(input logic rst, input logic mem, input logic we,
                        input logic [31:0] dm, input logic [31:0] alu,
                        input logic [4:0] wa, input logic [4:0] ra, input logic [4:0] rb,
                        input bit chk = 1'b1);
        exp_t        e;
        logic [31:0] wd;
        bit          v;
        @(posedge clk); #1;
        reset = rst; memToRegInput = mem; regWriteInput = we;
        dataMemoryInput = dm; aluResultInput = alu; regWriteAddressInput = wa;
        readAddressA = ra; readAddressB = rb;
        wd = mem ? dm : alu;
        v  = we && (wa != 0) && !rst;
        e.chk = chk;
        e.rda = ref_rd(ra, v, wa, wd);
        e.rdb = ref_rd(rb, v, wa, wd);
        e.wbd = wd;
        e.wbv = v;
        e.rc  = mcnt;
        sb.push_back(e);
        if (rst) begin
            for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
            mcnt = 32'h0;
        end else if (v) begin
            mdl[wa] = wd;
            mcnt    = mcnt + 32'd1;
        end
    endtask

    // Monitor: outputs are settled mid-cycle; compare against the oldest
    // queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.chk) begin
                    cmp("readDataA",      readDataA,             e.rda);
                    cmp("readDataB",      readDataB,             e.rdb);
                    cmp("writeBackData",  writeBackData,         e.wbd);
                    cmp("writeBackValid", {31'h0, writeBackValid}, {31'h0, e.wbv});
                    cmp("retireCount",    retireCount,           e.rc);
                end
            end
        end
    end

    initial begin
        logic [4:0]  wa, ra, rb;
        logic [31:0] d0, d1;
        bit          rst, we, mem;
        int          wait_cyc;

        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        mcnt = 32'h0;

        // Two reset cycles; contents are unknown until the first edge.
        step(1, 0, 0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0);
        step(1, 0, 0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd17);
        // Every index on both ports reads zero after reset.
        for (int i = 0; i < 32; i++)
            step(0, 0, 0, 32'h0, 32'h0, 5'd0, 5'(i), 5'(31 - i));

        // ALU write to r5, then load to r6; read back.
        step(0, 0, 1, 32'h0, 32'hDEADBEEF, 5'd5, 5'd1, 5'd2);
        step(0, 1, 1, 32'h12345678, 32'h0, 5'd6, 5'd5, 5'd4);
        step(0, 0, 0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd6);

        // Same-cycle bypass to both ports.
        step(0, 0, 1, 32'h0, 32'hCAFEF00D, 5'd7, 5'd7, 5'd7);
        step(0, 0, 0, 32'h0, 32'h0, 5'd0, 5'd7, 5'd7);

        // Write to r0 is a no-op.
        step(0, 0, 1, 32'h0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd5);
        step(0, 0, 0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);

        // Reset beats a concurrent write; bypass suppressed during reset.
        step(0, 0, 1, 32'h0, 32'h00001111, 5'd9, 5'd9, 5'd1);
        step(1, 0, 1, 32'h0, 32'hAAAA5555, 5'd9, 5'd9, 5'd9);
        step(0, 0, 0, 32'h0, 32'h0, 5'd0, 5'd9, 5'd5);
        // First write right after reset deasserts commits.
        step(0, 1, 1, 32'h0BADF00D, 32'h0, 5'd31, 5'd31, 5'd0);
        step(0, 0, 0, 32'h0, 32'h0, 5'd0, 5'd31, 5'd31);

        // Counter wrap via backdoor preload.
        @(posedge clk); #1;
        dut.retire_cnt = 32'hFFFFFFFE;
        mcnt           = 32'hFFFFFFFE;
        step(0, 0, 1, 32'h0, 32'h01010101, 5'd3, 5'd3, 5'd0);
        step(0, 0, 1, 32'h0, 32'h02020202, 5'd4, 5'd3, 5'd4);
        step(0, 0, 0, 32'h0, 32'h0, 5'd0, 5'd4, 5'd3);

        // Randomized traffic, biased toward address collisions.
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 49) == 0);
            we  = ($urandom_range(0, 9) < 7);
            mem = $urandom_range(0, 1);
            wa  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            ra  = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
            rb  = ($urandom_range(0, 3) == 0) ? ra : 5'($urandom_range(0, 31));
            d0  = $urandom;
            d1  = $urandom;
            step(rst, mem, we, d0, d1, wa, ra, rb);
        end
        step(0, 0, 0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);

        wait_cyc = 0;
        while (sb.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard drain: %0d entries left, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/writeback_regfile.md
WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the width of every data path and register entry.
REQ-002 Parameter ADDR_WIDTH, default 5, SHALL set the register address width, giving 2^ADDR_WIDTH entries.
REQ-003 clk  input  1  SHALL be the clock; all state updates on the rising edge.
REQ-004 reset  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 memToRegInput  input  1  SHALL select the writeback source: 1 = memory data, 0 = ALU result.
REQ-006 regWriteInput  input  1  SHALL request a register write this cycle.
REQ-007 dataMemoryInput  input  DATA_WIDTH  SHALL be the load data from the MEM/WB register.
REQ-008 aluResultInput  input  DATA_WIDTH  SHALL be the ALU result from the MEM/WB register.
REQ-009 regWriteAddressInput  input  ADDR_WIDTH  SHALL be the destination register index.
REQ-010 readAddressA / readAddressB  input  ADDR_WIDTH each  SHALL be the decode-stage source indices.
REQ-011 readDataA / readDataB  output  DATA_WIDTH each  SHALL be the source operands.
REQ-012 writeBackData  output  DATA_WIDTH  SHALL be the selected writeback value, for forwarding.
REQ-013 writeBackValid  output  1  SHALL flag that a write will commit at the next edge.
REQ-014 retireCount  output  32  SHALL count committed register writes.

Function
REQ-015 writeBackData SHALL be combinational: dataMemoryInput if memToRegInput=1, else aluResultInput.
REQ-016 writeBackValid SHALL be combinational: regWriteInput AND regWriteAddressInput!=0 AND reset=0.
REQ-017 On a rising edge with writeBackValid=1, entry[regWriteAddressInput] SHALL take writeBackData; no other entry changes.
REQ-018 Entry 0 SHALL never be written; any read of index 0 SHALL return 0, including under bypass.
REQ-019 Reads SHALL be combinational, zero-cycle latency, from the array.
REQ-020 Write-through bypass: if writeBackValid=1 and readAddressX==regWriteAddressInput, readDataX SHALL equal writeBackData in that same cycle.
REQ-021 Both read ports SHALL bypass independently; equal read addresses return identical data.
REQ-022 regWriteInput=1 with address 0 SHALL be a no-op: no array change, no bypass, no retireCount increment.
REQ-023 retireCount SHALL increment by 1 on each edge where writeBackValid=1; it wraps 0xFFFFFFFF -> 0x00000000.
REQ-024 memToRegInput and data inputs SHALL have no effect on state when writeBackValid=0.

Reset
REQ-025 On a rising edge with reset=1, all entries SHALL become 0 and retireCount SHALL become 0.
REQ-026 A write presented in a reset cycle SHALL be discarded; reset takes priority over write.
REQ-027 During reset=1, bypass SHALL be suppressed and reads SHALL return array contents (0 after the first reset edge).
REQ-028 The first write SHALL be accepted on the first edge after reset deasserts.

Verification
REQ-029 Reset for 2 cycles, then read all 32 indices on both ports -> every readData = 0, retireCount = 0.
REQ-030 Write 0xDEADBEEF to r5 via ALU (memToReg=0), then a load of 0x12345678 to r6 (memToReg=1) -> next cycle r5 = 0xDEADBEEF, r6 = 0x12345678, retireCount = 2.
REQ-031 Write 0xCAFEF00D to r7 while readAddressA=readAddressB=7 -> both ports show 0xCAFEF00D in the same cycle; writeBackValid = 1.
REQ-032 Write 0xFFFFFFFF to r0 while readAddressA=0 -> readDataA = 0 both in that cycle and the next; retireCount unchanged.
REQ-033 Assert reset while writing 0xAAAA5555 to r9 -> after the edge r9 = 0, retireCount = 0; bypass inactive during reset.
REQ-034 Force retireCount to 0xFFFFFFFF through 2^32-1 valid writes (or a backdoor preload), then one more write -> retireCount = 0x00000000.
